imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Hardware counterpart of the bench's hex preload. Receives a framed byte stream, for example from a UART receiver or a debug port.
- Assembles the stream into 32-bit instruction words and writes them into the instruction memory.
- Holds the single-cycle core's PC clear until a complete, checksum-verified program is loaded.
- Sits between the byte source and the instruction memory write port. Its cpu_hold output drives the core's clr_PC.

Parameters:
- ADDR_W, 10: instruction memory word-address width.
- MAX_WORDS, 1024: largest accepted word count.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle re-arm pulse. Returns the block to IDLE from any state.
- byte_in  in  8  stream byte.
- byte_in_valid  in  1  byte_in is valid.
- byte_in_ready  out  1  loader can accept a byte. A byte transfers when valid and ready are both high on a clk edge.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  instruction word.
- cpu_hold  out  1  connect to the core's clr_PC. High means the core is held at PC=0.
- done  out  1  load completed with a good checksum.
- err  out  1  frame error. Sticky.

Behaviour:
- Frame format: SYNC_BYTE, count_hi, count_lo, count×4 data bytes (each word MSB first), checksum.
  - Checksum = sum of data bytes mod 256. The sync and count bytes are excluded.
- Reset values (async clr): state=IDLE, byte_in_ready=0 for the first cycle after release, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0. Word index, byte counter and checksum accumulator all =0.
- byte_in_ready=1 in IDLE, CNT_HI, CNT_LO, DATA and CHK. It is 0 in DONE and ERROR, and 0 in any cycle where start=1.
- State transitions (all on an accepted byte unless stated):
  - IDLE: byte == SYNC_BYTE → CNT_HI. Any other byte is discarded and the state stays IDLE.
  - CNT_HI: latch count[15:8] → CNT_LO.
  - CNT_LO: latch count[7:0].
    - count > MAX_WORDS → ERROR.
    - count == 0 → CHK.
    - otherwise → DATA.
  - DATA: shift byte into a 32-bit assembler (first byte lands in [31:24]) and add it to the checksum.
    - On the 4th byte of a word, register imem_wdata=assembled word and imem_addr=word index; imem_we=1 for exactly the next cycle. Then increment the word index.
    - After the last word's 4th byte → CHK.
  - CHK: byte == accumulated sum → DONE; otherwise → ERROR.
  - DONE: done=1, cpu_hold=0. Stays in DONE until start or clr.
  - ERROR: err=1, cpu_hold=1. Stays in ERROR until start or clr.
- Write latency: imem_we asserts 1 cycle after the handshake of a word's 4th byte. With back-to-back bytes, the minimum spacing between strobes is 4 cycles.
- Between strobes, imem_addr and imem_wdata hold their last values.
- start, from any state:
  - next state IDLE;
  - done=0, err=0, cpu_hold=1;
  - counters and checksum cleared.
  - A byte presented in the same cycle is not accepted, because ready is forced low.
- clr mid-transfer: immediate async return to reset values. Words already written stay in memory. There is no rollback, and none is needed because cpu_hold stays high.
- Bad checksum: memory already contains the new words, but cpu_hold stays high, so the core never runs an unverified image.
- Word address arithmetic: the index is ADDR_W bits and counts 0..count-1. It never wraps, because count ≤ MAX_WORDS ≤ 2^ADDR_W is enforced in CNT_LO.
- byte_in_valid low in any state: the state holds and no side effects occur. Gaps of any length are allowed.

Test Plan:
- Factorial image: A5 00 07, then 200100c8 28020001 14411000 2c210001 3420fffd 240200c6 fc000000, then checksum FF.
  - Required: 7 imem_we pulses at addr 0..6 with those words; then done=1 and cpu_hold=0.
  - With the core attached and data_mem[200]=5, data_mem[198]=120 afterwards.
- Empty frame: A5 00 00 00 → done=1, no imem_we pulse. The same frame with checksum 01 → err=1, cpu_hold=1.
- Bad checksum: the factorial frame with checksum FE → 7 writes occur, then err=1, done=0, cpu_hold=1, byte_in_ready=0.
- Oversize and garbage:
  - Bytes 00 3C A5 04 01 → the first two bytes are discarded; err=1 right after the 5th byte (count 0x0401 > 1024); no writes.
  - Count exactly 1024 is accepted, and its last write lands at addr 1023.
- Re-arm and reset:
  - start pulsed after word 2 of the factorial frame → IDLE, the byte in the start cycle is not accepted, and a fresh full frame then loads cleanly.
  - clr asserted mid-word → all outputs reset asynchronously, with no glitch on imem_we.
- Backpressure timing: byte_in_valid toggled randomly with 0–5 idle cycles between bytes → identical writes and result to the first scenario. Each imem_we lands exactly 1 cycle after its 4th byte handshake.

Source files
------------

// File: rtl/imem_program_loader.sv
// Framed byte-stream loader for the instruction memory. It assembles 32-bit words MSB-first
// and holds the core's PC clear until a complete image with a verified checksum is loaded.
//
// state  | meaning
// IDLE   | waiting for the sync byte, any other byte is discarded
// CNT_HI | expecting the upper byte of the word count
// CNT_LO | expecting the lower byte of the word count; range check
// DATA   | assembling data bytes and issuing one memory write per word
// CHK    | expecting the checksum byte
// DONE   | image verified, core released
// ERROR  | bad count or checksum, core held

module imem_program_loader #(
    parameter int          ADDR_W    = 10,
    parameter int          MAX_WORDS = 1024,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_in_valid,
    output logic              byte_in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, DATA, CHK, DONE, ERROR
    } state_t;

    localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

    state_t            state, nxt;
    logic              ready_en;
    logic [15:0]       count;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_buf;
    logic [7:0]        csum;

    logic              accept_state;
    logic              xfer;
    logic [15:0]       count_full;
    logic              last_byte;

    always_comb begin
        accept_state = 1'b0;
        case (state)
            IDLE, CNT_HI, CNT_LO, DATA, CHK: accept_state = 1'b1;
            default:                         accept_state = 1'b0;
        endcase
    end

    // ready_en keeps the loader deaf for the first cycle after reset release
    assign byte_in_ready = ready_en && accept_state && !start;
    assign xfer          = byte_in_valid && byte_in_ready;
    assign count_full    = {count[15:8], byte_in};
    assign last_byte     = (byte_cnt == 2'd3) && (16'(word_idx) == (count - 16'd1));

    assign done     = (state == DONE);
    assign err      = (state == ERROR);
    assign cpu_hold = (state != DONE);

    always_comb begin
        nxt = state;
        if (start) begin
            nxt = IDLE;
        end else if (xfer) begin
            case (state)
                IDLE:   if (byte_in == SYNC_BYTE) nxt = CNT_HI;
                CNT_HI: nxt = CNT_LO;
                CNT_LO: begin
                    if (count_full > MAX_CNT)      nxt = ERROR;
                    else if (count_full == 16'd0)  nxt = CHK;
                    else                           nxt = DATA;
                end
                DATA:   if (last_byte) nxt = CHK;
                CHK:    nxt = (byte_in == csum) ? DONE : ERROR;
                default: nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= nxt;
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            asm_buf    <= '0;
            csum       <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                count    <= '0;
                word_idx <= '0;
                byte_cnt <= '0;
                asm_buf  <= '0;
                csum     <= '0;
            end else if (xfer) begin
                case (state)
                    IDLE: begin
                        word_idx <= '0;
                        byte_cnt <= '0;
                        csum     <= '0;
                    end
                    CNT_HI: count[15:8] <= byte_in;
                    CNT_LO: count[7:0]  <= byte_in;
                    DATA: begin
                        csum     <= csum + byte_in;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {asm_buf, byte_in};
                            imem_addr  <= word_idx;
                            word_idx   <= word_idx + 1'b1;
                        end else begin
                            asm_buf <= {asm_buf[15:0], byte_in};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: the driver queues expected writes, a negedge
// monitor checks each imem_we strobe for address, data and cycle.

module tb_imem_program_loader;

    localparam int         ADDR_W = 10;
    localparam logic [7:0] SYNC   = 8'hA5;

    logic              clk = 1'b0;
    logic              clr;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_in_valid;
    logic              byte_in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    imem_program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024), .SYNC_BYTE(SYNC)) dut (
        .clk           (clk),
        .clr           (clr),
        .start         (start),
        .byte_in       (byte_in),
        .byte_in_valid (byte_in_valid),
        .byte_in_ready (byte_in_ready),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        int                c;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_addr = -1;
    logic [31:0] img [1024];
    logic [31:0] fact [7] = '{32'h200100c8, 32'h28020001, 32'h14411000, 32'h2c210001,
                              32'h3420fffd, 32'h240200c6, 32'hfc000000};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.a));
                check("write_data", imem_wdata, e.d);
                check("write_cycle", cyc, e.c);
                last_addr = int'(imem_addr);
            end
        end
    end

    function automatic int rgap(input int m);
        return (m == 0) ? 0 : int'($urandom_range(m, 0));
    endfunction

    function automatic logic [7:0] calc_ck(input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++)
            s = s + img[i][31:24] + img[i][23:16] + img[i][15:8] + img[i][7:0];
        return s;
    endfunction

    task automatic load_fact();
        for (int i = 0; i < 7; i++) img[i] = fact[i];
    endtask

    // Called and returns at posedge+1; queues the expected write for a word's 4th byte.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit wr,
                             input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bit ok = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_in       = b;
        byte_in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (byte_in_ready) begin
                ok = 1'b1;
                if (wr) exp_q.push_back('{a, d, cyc + 1});
            end
            @(posedge clk);
        end
        #1;
        byte_in_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: byte 0x%0h not accepted within 50 cycles", b);
        end
    endtask

    task automatic send_frame(input int n, input logic [7:0] ck, input int maxgap,
                              input int data_limit);
        int         nb;
        logic [7:0] b;
        nb = (data_limit < 0) ? n * 4 : data_limit;
        send_byte(SYNC, rgap(maxgap), 1'b0, '0, '0);
        send_byte(8'(n >> 8), rgap(maxgap), 1'b0, '0, '0);
        send_byte(8'(n), rgap(maxgap), 1'b0, '0, '0);
        for (int k = 0; k < nb; k++) begin
            b = 8'(img[k / 4] >> (8 * (3 - (k % 4))));
            send_byte(b, rgap(maxgap), (k % 4) == 3, ADDR_W'(k / 4), img[k / 4]);
        end
        if (data_limit < 0) send_byte(ck, rgap(maxgap), 1'b0, '0, '0);
    endtask

    task automatic pulse_start(input bit with_byte);
        start = 1'b1;
        if (with_byte) begin
            byte_in       = SYNC;
            byte_in_valid = 1'b1;
        end
        #1;
        check("ready_during_start", 32'(byte_in_ready), 32'd0);
        @(posedge clk);
        #1;
        start         = 1'b0;
        byte_in_valid = 1'b0;
        check("start_done", 32'(done), 32'd0);
        check("start_err", 32'(err), 32'd0);
        check("start_hold", 32'(cpu_hold), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byte_in_ready), 32'd0);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic check_result(input string tag, input bit exp_done);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(!exp_done));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
        check({tag, "_ready"}, 32'(byte_in_ready), 32'd0);
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    initial begin
        clr           = 1'b1;
        start         = 1'b0;
        byte_in       = 8'h00;
        byte_in_valid = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        check("ready_first_cycle", 32'(byte_in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(byte_in_ready), 32'd1);

        // factorial image, back-to-back bytes
        load_fact();
        send_frame(7, 8'hFF, 0, -1);
        check_result("fact", 1'b1);
        check("fact_last_addr", 32'(last_addr), 32'd6);

        pulse_start(1'b0);
        send_frame(0, 8'h00, 0, -1);
        check_result("empty", 1'b1);

        pulse_start(1'b0);
        send_frame(0, 8'h01, 0, -1);
        check_result("empty_badck", 1'b0);

        pulse_start(1'b0);
        send_frame(7, 8'hFE, 0, -1);
        check_result("badck", 1'b0);

        // garbage, then oversize count 0x0401
        pulse_start(1'b0);
        send_byte(8'h00, 0, 1'b0, '0, '0);
        send_byte(8'h3C, 0, 1'b0, '0, '0);
        send_byte(SYNC, 0, 1'b0, '0, '0);
        send_byte(8'h04, 0, 1'b0, '0, '0);
        send_byte(8'h01, 0, 1'b0, '0, '0);
        check_result("oversize", 1'b0);

        // largest legal image, word i = i
        pulse_start(1'b0);
        for (int i = 0; i < 1024; i++) img[i] = 32'(i);
        send_frame(1024, calc_ck(1024), 0, -1);
        check_result("max_count", 1'b1);
        check("max_last_addr", 32'(last_addr), 32'd1023);

        // re-arm after two words; the sync byte offered during start must be ignored
        load_fact();
        pulse_start(1'b0);
        send_frame(7, 8'hFF, 0, 8);
        pulse_start(1'b1);
        send_frame(7, 8'hFF, 0, -1);
        check_result("rearm", 1'b1);

        // async clear while the first word's strobe is high
        pulse_start(1'b0);
        send_frame(7, 8'hFF, 0, 4);
        check("we_before_clr", 32'(imem_we), 32'd1);
        @(negedge clk);
        #1;
        clr = 1'b1;
        #1;
        check_reset_outputs("clr_mid");
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;

        // random backpressure gaps of 0..5 cycles
        send_frame(7, 8'hFF, 5, -1);
        check_result("backpressure", 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("final_pending_writes", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
